// File: rtl/dummy_issuer.sv
// dummy_issuer: core-side issue/response controller for the dummy coprocessor.
// Forwards tagged requests with their mode, returns results in order with their
// original tag, and enforces the coprocessor's mode rules (pipelined ops up to
// MAX_OUTST in flight, a single iterative op, full drain before a mode change).
// Optional feature: define DUMMY_ISSUER_RSP_REG_EN to add a one-entry registered
// response stage between the coprocessor and the core.
`timescale 1ns/1ps

package dummy_pkg;
    typedef enum logic {MODE_PIPE = 1'b0, MODE_ITER = 1'b1} coproc_ctl_t;
endpackage

module dummy_issuer
    import dummy_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int TAG_W     = 4,
    parameter  int MAX_OUTST = 4,
    localparam int CNT_W     = $clog2(MAX_OUTST + 1),
    localparam int PTR_W     = $clog2(MAX_OUTST)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  coproc_ctl_t       req_mode_i,
    input  logic [DATA_W-1:0] req_op_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [TAG_W-1:0]  rsp_tag_o,
    output logic              cp_valid_o,
    input  logic              cp_ready_i,
    output coproc_ctl_t       cp_ctl_o,
    output logic [DATA_W-1:0] cp_op_o,
    input  logic              cp_valid_i,
    output logic              cp_ready_o,
    input  logic [DATA_W-1:0] cp_res_i,
    output logic              cp_flush_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  outst_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

    state_t            state_q, state_d;
    coproc_ctl_t       mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_mem [MAX_OUTST];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;

    logic              can_issue, issue, retire, cnt_nz, live, slot_free;
    logic              bypass, push, pop, cp_ready_int;
    logic              rsp_valid_int, busy_int;
    logic [DATA_W-1:0] rsp_data_int;
    logic [TAG_W-1:0]  rsp_tag_int, ret_tag;

    // Issue permission from the mode rules; flush blocks issue so the core never
    // sees a request accepted in the same cycle that in-flight state is dropped.
    always_comb begin
        can_issue = 1'b0;
        unique case (state_q)
            S_IDLE:  can_issue = 1'b1;
            S_BUSY:  if (req_mode_i == mode_q)
                         can_issue = (mode_q == MODE_PIPE) ? (cnt_q < CNT_W'(MAX_OUTST)) : !cnt_nz;
            default: can_issue = 1'b0;
        endcase
        if (flush_i) can_issue = 1'b0;
    end

    assign cnt_nz = (cnt_q != '0);
    assign issue  = req_valid_i & cp_ready_i & can_issue;
    // Only accept results for ops actually in flight (or issuing right now).
    assign live   = cnt_nz | issue;

`ifdef DUMMY_ISSUER_RSP_REG_EN
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [TAG_W-1:0]  rsp_tag_q;

    assign slot_free = ~rsp_valid_q | rsp_ready_i;

    // One-entry response stage; a new capture overwrites a slot being consumed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
        end else if (flush_i) begin
            rsp_valid_q <= 1'b0;
        end else if (retire) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cp_res_i;
            rsp_tag_q   <= ret_tag;
        end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_int = rsp_valid_q;
    assign rsp_data_int  = rsp_data_q;
    assign rsp_tag_int   = rsp_tag_q;
    assign busy_int      = cnt_nz | rsp_valid_q;
`else
    assign slot_free     = rsp_ready_i;
    assign rsp_valid_int = cp_valid_i & live & ~flush_i;
    assign rsp_data_int  = cp_res_i;
    assign rsp_tag_int   = ret_tag;
    assign busy_int      = cnt_nz;
`endif

    assign cp_ready_int = live & slot_free & ~flush_i;
    assign retire       = cp_valid_i & cp_ready_int;

    // FIFO occupancy always equals cnt_q, so cnt_q == 0 means the FIFO is empty.
    assign bypass  = issue & retire & ~cnt_nz;
    assign push    = issue & ~bypass;
    assign pop     = retire & ~bypass;
    assign ret_tag = cnt_nz ? tag_mem[rd_ptr_q] : req_tag_i;

    // Outstanding count and FSM next state.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        mode_d  = mode_q;
        if (issue && !retire)      cnt_d = cnt_q + CNT_W'(1);
        else if (retire && !issue) cnt_d = cnt_q - CNT_W'(1);
        unique case (state_q)
            S_IDLE: if (issue) begin
                state_d = S_BUSY;
                mode_d  = req_mode_i;
            end
            S_BUSY: begin
                if (cnt_d == '0 && !issue)                      state_d = S_IDLE;
                else if (req_valid_i && req_mode_i != mode_q)   state_d = S_DRAIN;
            end
            S_DRAIN: if (cnt_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state; flush wins over any same-cycle handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_PIPE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Tag storage; contents are don't-care while the pointers mark it empty.
    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr_q] <= req_tag_i;
    end

    // All outputs held at zero while reset is asserted.
    assign req_ready_o = ~rst_i & cp_ready_i & can_issue;
    assign cp_valid_o  = ~rst_i & req_valid_i & can_issue;
    assign cp_ctl_o    = rst_i ? MODE_PIPE : req_mode_i;
    assign cp_op_o     = rst_i ? '0 : req_op_i;
    assign cp_flush_o  = ~rst_i & flush_i;
    assign cp_ready_o  = ~rst_i & cp_ready_int;
    assign rsp_valid_o = ~rst_i & rsp_valid_int;
    assign rsp_data_o  = rst_i ? '0 : rsp_data_int;
    assign rsp_tag_o   = rst_i ? '0 : rsp_tag_int;
    assign busy_o      = ~rst_i & busy_int;
    assign outst_cnt_o = rst_i ? '0 : cnt_q;

endmodule

// File: tb/tb_dummy_issuer.sv
// Bench for dummy_issuer: directed scenarios followed by randomized PIPE traffic
// checked against a queue-based reference model of the issue/return contract.
`timescale 1ns/1ps

module tb_dummy_issuer;
    import dummy_pkg::*;

    localparam int DATA_W    = 32;
    localparam int TAG_W     = 4;
    localparam int MAX_OUTST = 4;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic              clk_i = 1'b0;
    logic              rst_i, flush_i, req_valid_i, rsp_ready_i, cp_ready_i, cp_valid_i;
    coproc_ctl_t       req_mode_i, cp_ctl_o;
    logic [DATA_W-1:0] req_op_i, cp_res_i, rsp_data_o, cp_op_o;
    logic [TAG_W-1:0]  req_tag_i, rsp_tag_o;
    logic              req_ready_o, rsp_valid_o, cp_valid_o, cp_ready_o, cp_flush_o, busy_o;
    logic [CNT_W-1:0]  outst_cnt_o;

    always #5 clk_i = ~clk_i;

    dummy_issuer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_mode_i(req_mode_i),
        .req_op_i(req_op_i), .req_tag_i(req_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_tag_o(rsp_tag_o),
        .cp_valid_o(cp_valid_o), .cp_ready_i(cp_ready_i), .cp_ctl_o(cp_ctl_o), .cp_op_o(cp_op_o),
        .cp_valid_i(cp_valid_i), .cp_ready_o(cp_ready_o), .cp_res_i(cp_res_i),
        .cp_flush_o(cp_flush_o), .busy_o(busy_o), .outst_cnt_o(outst_cnt_o)
    );

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } rsp_t;

    int   errors = 0;
    int   checks = 0;
    rsp_t got_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Settle point between edges; also records every completed core response.
    task automatic at_neg();
        @(negedge clk_i);
        if (rsp_valid_o === 1'b1 && rsp_ready_i) got_q.push_back({rsp_tag_o, rsp_data_o});
    endtask

    task automatic to_pos();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        flush_i = 0; req_valid_i = 0; req_mode_i = MODE_PIPE; req_op_i = '0; req_tag_i = '0;
        cp_ready_i = 1; cp_valid_i = 0; cp_res_i = '0; rsp_ready_i = 1;
    endtask

    task automatic idle_cycles(input int n);
        idle_in();
        for (int i = 0; i < n; i++) begin at_neg(); to_pos(); end
    endtask

    task automatic send(input coproc_ctl_t m, input logic [DATA_W-1:0] op, input logic [TAG_W-1:0] t);
        req_valid_i = 1; req_mode_i = m; req_op_i = op; req_tag_i = t;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {req_ready_o, cp_valid_o, cp_ready_o, rsp_valid_o, busy_o,
                             cp_flush_o, cp_ctl_o, outst_cnt_o, rsp_tag_o}, 64'h0);
        chk({name, "_data"}, {cp_op_o, rsp_data_o}, 64'h0);
    endtask

    task automatic chk_got(input string name, input int n, input logic [TAG_W-1:0] t0,
                           input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                           input logic [TAG_W-1:0] t3, input logic [TAG_W-1:0] t4,
                           input logic [DATA_W-1:0] d0);
        logic [TAG_W-1:0] tags [5];
        tags = '{t0, t1, t2, t3, t4};
        chk({name, "_count"}, got_q.size(), n);
        for (int k = 0; k < n && k < got_q.size(); k++) begin
            chk({name, "_tag"}, got_q[k].tag, tags[k]);
            if (k == 0) chk({name, "_data"}, got_q[k].data, d0);
        end
    endtask

    // Random-phase model state
    int               m_cnt;
    logic [TAG_W-1:0] tq[$];
    logic [DATA_W-1:0] opq[$];
    logic             m_rv, fl, e_rr, e_iss, slot, e_cpr, ret, byp;
    rsp_t             m_rsp, item;

    initial begin
        // ---- reset: outputs forced low even with busy-looking inputs ----
        idle_in();
        req_valid_i = 1; flush_i = 1; cp_valid_i = 1; req_op_i = '1; cp_res_i = '1;
        req_tag_i = '1; req_mode_i = MODE_ITER;
        rst_i = 1;
        #12;
        chk_zero("reset");
        to_pos();
        rst_i = 0;
        idle_in();
        at_neg();
        chk("reset_cnt", outst_cnt_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_req_ready", req_ready_o, 1);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        to_pos();

        // ---- single PIPE op, result two cycles after issue ----
        got_q.delete();
        send(MODE_PIPE, 32'h10, 4'd3);
        at_neg();
        chk("t1_cp_valid", cp_valid_o, 1);
        chk("t1_cp_op", cp_op_o, 32'h10);
        chk("t1_cp_ctl", cp_ctl_o, MODE_PIPE);
        chk("t1_req_ready", req_ready_o, 1);
        to_pos();
        idle_in();
        chk("t1_cnt1", outst_cnt_o, 1);
        chk("t1_busy", busy_o, 1);
        at_neg(); to_pos();
        cp_valid_i = 1; cp_res_i = 32'h11;
        at_neg();
        chk("t1_cp_ready", cp_ready_o, 1);
`ifdef DUMMY_ISSUER_RSP_REG_EN
        chk("t1_rsp_early", rsp_valid_o, 0);
        to_pos();
        cp_valid_i = 0;
        chk("t1_rsp_valid", rsp_valid_o, 1);
        chk("t1_rsp_data", rsp_data_o, 32'h11);
        chk("t1_rsp_tag", rsp_tag_o, 3);
`else
        chk("t1_rsp_valid", rsp_valid_o, 1);
        chk("t1_rsp_data", rsp_data_o, 32'h11);
        chk("t1_rsp_tag", rsp_tag_o, 3);
        to_pos();
        cp_valid_i = 0;
`endif
        chk("t1_cnt0", outst_cnt_o, 0);
        idle_cycles(2);

        // ---- five back-to-back PIPE ops, limit of four in flight ----
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            send(MODE_PIPE, 32'h20 + i, 4'(i));
            at_neg();
            chk("t2_req_ready", req_ready_o, 1);
            to_pos();
        end
        chk("t2_cnt_full", outst_cnt_o, 4);
        send(MODE_PIPE, 32'h24, 4'd4);
        at_neg();
        chk("t2_stall_ready", req_ready_o, 0);
        chk("t2_stall_valid", cp_valid_o, 0);
        to_pos();
        cp_valid_i = 1; cp_res_i = 32'h21;
        at_neg();
        chk("t2_stall_on_retire", req_ready_o, 0);
        chk("t2_cp_ready", cp_ready_o, 1);
        to_pos();
        cp_valid_i = 0;
        at_neg();
        chk("t2_fifth_issue", req_ready_o, 1);
        to_pos();
        req_valid_i = 0;
        for (int k = 1; k <= 4; k++) begin
            cp_valid_i = 1; cp_res_i = 32'h21 + k;
            at_neg();
            chk("t2_drain_ready", cp_ready_o, 1);
            to_pos();
        end
        idle_cycles(3);
        chk_got("t2", 5, 0, 1, 2, 3, 4, 32'h21);

        // ---- ITER op outstanding, second ITER op waits ----
        got_q.delete();
        send(MODE_ITER, 32'h70, 4'd7);
        at_neg();
        chk("t3_first_issue", req_ready_o, 1);
        to_pos();
        send(MODE_ITER, 32'h80, 4'd8);
        at_neg();
        chk("t3_second_stall", cp_valid_o, 0);
        to_pos();
        cp_valid_i = 1; cp_res_i = 32'h71;
        at_neg();
        chk("t3_stall_on_retire", cp_valid_o, 0);
        to_pos();
        cp_valid_i = 0;
        at_neg();
        chk("t3_second_issue", cp_valid_o, 1);
        chk("t3_second_ctl", cp_ctl_o, MODE_ITER);
        to_pos();
        req_valid_i = 0; cp_valid_i = 1; cp_res_i = 32'h81;
        at_neg(); to_pos();
        idle_cycles(3);
        chk_got("t3", 2, 7, 8, 0, 0, 0, 32'h71);

        // ---- mode change drains PIPE ops before ITER issues ----
        got_q.delete();
        send(MODE_PIPE, 32'h11, 4'd1); at_neg(); to_pos();
        send(MODE_PIPE, 32'h12, 4'd2); at_neg(); to_pos();
        chk("t4_cnt2", outst_cnt_o, 2);
        send(MODE_ITER, 32'h55, 4'd5);
        at_neg();
        chk("t4_mismatch_stall", cp_valid_o, 0);
        to_pos();
        for (int k = 0; k < 2; k++) begin
            cp_valid_i = 1; cp_res_i = 32'h12 + k;
            at_neg();
            chk("t4_drain_stall", cp_valid_o, 0);
            to_pos();
        end
        cp_valid_i = 0;
        chk("t4_drained", outst_cnt_o, 0);
        at_neg();
        chk("t4_iter_issue", cp_valid_o, 1);
        chk("t4_iter_ctl", cp_ctl_o, MODE_ITER);
        to_pos();
        req_valid_i = 0; cp_valid_i = 1; cp_res_i = 32'h56;
        at_neg(); to_pos();
        idle_cycles(3);
        chk_got("t4", 3, 1, 2, 5, 0, 0, 32'h12);

        // ---- same-cycle issue and result with nothing in flight ----
        got_q.delete();
        send(MODE_PIPE, 32'h90, 4'd9);
        cp_valid_i = 1; cp_res_i = 32'h91;
        at_neg();
        chk("t5_cp_ready", cp_ready_o, 1);
        to_pos();
        idle_in();
        chk("t5_cnt", outst_cnt_o, 0);
        idle_cycles(2);
        chk_got("t5", 1, 9, 0, 0, 0, 0, 32'h91);

        // ---- flush with ops in flight ----
        for (int i = 0; i < 3; i++) begin
            send(MODE_PIPE, 32'hA0 + i, 4'(10 + i)); at_neg(); to_pos();
        end
        req_valid_i = 0; rsp_ready_i = 0; cp_valid_i = 1; cp_res_i = 32'hA1;
        at_neg(); to_pos();
        chk("t6_busy_pre", busy_o, 1);
        cp_valid_i = 0; flush_i = 1;
        at_neg();
        chk("t6_cp_flush", cp_flush_o, 1);
        to_pos();
        flush_i = 0; cp_valid_i = 1; cp_res_i = 32'hBAD;
        chk("t6_cnt", outst_cnt_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_rsp_valid", rsp_valid_o, 0);
        at_neg();
        chk("t6_unsolicited", cp_ready_o, 0);
        to_pos();
        idle_cycles(1);

        // ---- reset in the middle of a transfer ----
        send(MODE_PIPE, 32'hC0, 4'd1); at_neg(); to_pos();
        send(MODE_PIPE, 32'hC1, 4'd2); cp_valid_i = 1; cp_res_i = 32'hC1;
        rst_i = 1;
        #1;
        chk_zero("t7_reset");
        to_pos();
        rst_i = 0;
        idle_in();
        #1;
        chk("t7_cnt", outst_cnt_o, 0);
        chk("t7_busy", busy_o, 0);
        to_pos();

        // ---- randomized PIPE traffic against the reference model ----
        m_cnt = 0; m_rv = 0; m_rsp = '0; tq.delete(); opq.delete();
        for (int c = 0; c < 600; c++) begin
            fl          = ($urandom_range(0, 49) == 0);
            flush_i     = fl;
            req_valid_i = !fl && ($urandom_range(0, 3) != 0);
            req_mode_i  = MODE_PIPE;
            req_op_i    = $urandom;
            req_tag_i   = 4'($urandom_range(0, 15));
            cp_ready_i  = ($urandom_range(0, 3) != 0);
            rsp_ready_i = ($urandom_range(0, 2) != 0);
            if (fl) cp_valid_i = 0;
            else if (opq.size() != 0) begin
                cp_valid_i = ($urandom_range(0, 2) != 0); cp_res_i = opq[0] + 1;
            end else begin
                cp_valid_i = ($urandom_range(0, 4) == 0); cp_res_i = req_op_i + 1;
            end
            @(negedge clk_i);
            if (fl) begin
                chk("r_flush", cp_flush_o, 1);
                tq.delete(); opq.delete(); m_cnt = 0; m_rv = 0;
            end else begin
                e_rr  = cp_ready_i && (m_cnt < MAX_OUTST);
                e_iss = req_valid_i && e_rr;
`ifdef DUMMY_ISSUER_RSP_REG_EN
                slot = !m_rv || rsp_ready_i;
`else
                slot = rsp_ready_i;
`endif
                e_cpr = (m_cnt != 0 || e_iss) && slot;
                chk("r_req_ready", req_ready_o, e_rr);
                chk("r_cp_valid", cp_valid_o, req_valid_i && (m_cnt < MAX_OUTST));
                chk("r_cp_ready", cp_ready_o, e_cpr);
                if (e_iss) chk("r_cp_op", cp_op_o, req_op_i);
                ret = cp_valid_i && e_cpr;
                byp = ret && (tq.size() == 0);
                item = '0;
                if (ret) begin
                    item.data = cp_res_i;
                    if (byp) item.tag = req_tag_i;
                    else begin item.tag = tq.pop_front(); void'(opq.pop_front()); end
                end
`ifdef DUMMY_ISSUER_RSP_REG_EN
                chk("r_rsp_valid", rsp_valid_o, m_rv);
                if (m_rv) begin
                    chk("r_rsp_tag", rsp_tag_o, m_rsp.tag);
                    chk("r_rsp_data", rsp_data_o, m_rsp.data);
                end
                if (ret) begin m_rv = 1; m_rsp = item; end
                else if (rsp_ready_i) m_rv = 0;
`else
                chk("r_rsp_valid", rsp_valid_o, cp_valid_i && (m_cnt != 0 || e_iss));
                if (ret) begin
                    chk("r_rsp_tag", rsp_tag_o, item.tag);
                    chk("r_rsp_data", rsp_data_o, item.data);
                end
`endif
                if (e_iss && !byp) begin tq.push_back(req_tag_i); opq.push_back(req_op_i); end
                m_cnt = m_cnt + (e_iss ? 1 : 0) - (ret ? 1 : 0);
            end
            to_pos();
            chk("r_cnt", outst_cnt_o, m_cnt);
            chk("r_busy", busy_o, (m_cnt != 0) || m_rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
